// File: rtl/la_iosequencer.sv
// IO-ring power sequencer: brings ring sides up one at a time once vddio is good,
// takes them down in reverse order on request, and drops everything on supply loss.
module la_iosequencer #(
  parameter int SIDES = 4,
  parameter int DELAY = 16,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwrgood,
  input  logic             req,
  output logic [SIDES-1:0] side_en,
  output logic [SIDES-1:0] side_iso,
  output logic             ready,
  output logic             busy,
  output logic             fault
);

  localparam int IW = (SIDES > 1) ? $clog2(SIDES) : 1;
  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(SIDES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

  typedef enum logic [2:0] {ST_OFF, ST_UP, ST_ON, ST_DOWN, ST_FAULT} state_t;

  state_t           state_q, state_d;
  logic [SYNC-1:0]  sync_q, sync_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SIDES-1:0] side_en_q, side_en_d;
  logic [SIDES-1:0] side_iso_q;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  logic             pg_s;
  logic             any_en;
  logic             cur_set;
  logic [IW-1:0]    top_idx;

  assign sync_d = {sync_q[SYNC-2:0], pwrgood};
  assign pg_s   = sync_q[SYNC-1];

  // Highest enabled side and the enable bit at idx, found by search so that
  // idx never has to be a legal bit-select width for every SIDES.
  always_comb begin
    top_idx = '0;
    cur_set = 1'b0;
    any_en  = |side_en_q;
    for (int i = 0; i < SIDES; i++) begin
      if (side_en_q[i]) top_idx = IW'(i);
      if (IW'(i) == idx_q) cur_set = side_en_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    side_en_d = side_en_q;
    ready_d   = ready_q;
    fault_d   = fault_q;
    case (state_q)
      ST_OFF: begin
        if (req && pg_s && !fault_q) begin
          state_d = ST_UP;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_UP: begin
        if (!req) begin
          cnt_d = '0;
          if (any_en) begin
            state_d = ST_DOWN;
            idx_d   = top_idx;
          end else begin
            state_d = ST_OFF;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // The last side being already on means its settle period just ended.
          if (cur_set) begin
            state_d = ST_ON;
            ready_d = 1'b1;
          end else begin
            for (int i = 0; i < SIDES; i++)
              if (IW'(i) == idx_q) side_en_d[i] = 1'b1;
            if (idx_q != IDX_LAST) idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ON: begin
        if (!req) begin
          state_d = ST_DOWN;
          idx_d   = IDX_LAST;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      ST_DOWN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          for (int i = 0; i < SIDES; i++)
            if (IW'(i) == idx_q) side_en_d[i] = 1'b0;
          if (idx_q != '0) idx_d = idx_q - IW'(1);
          else             state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FAULT: begin
        if (!req) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Supply loss overrides whatever the request logic decided above.
    if (!pg_s && (state_q == ST_UP || state_q == ST_ON || state_q == ST_DOWN)) begin
      state_d   = ST_FAULT;
      side_en_d = '0;
      ready_d   = 1'b0;
      fault_d   = 1'b1;
    end
    busy_d = (state_d == ST_UP) || (state_d == ST_DOWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OFF;
      sync_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      side_en_q  <= '0;
      side_iso_q <= '1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      side_en_q  <= side_en_d;
      side_iso_q <= ~side_en_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign side_en  = side_en_q;
  assign side_iso = side_iso_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_la_iosequencer.sv
// Bench for la_iosequencer: directed vector table, async reset and single-side
// sequences, then random req/pwrgood traffic against a timing-based model.
module tb_la_iosequencer;
  localparam int S  = 4;
  localparam int D  = 3;
  localparam int SY = 2;
  localparam int M_OFF = 0, M_RISE = 1, M_ON = 2, M_FALL = 3, M_FAULT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, pwrgood, req;
  logic [S-1:0] side_en, side_iso;
  logic         ready, busy, fault;
  logic         pwrgood_b, req_b;
  logic [0:0]   side_en_b, side_iso_b;
  logic         ready_b, busy_b, fault_b;

  la_iosequencer #(.SIDES(S), .DELAY(D), .SYNC(SY)) dut_a (
    .clk(clk), .reset(reset), .pwrgood(pwrgood), .req(req),
    .side_en(side_en), .side_iso(side_iso), .ready(ready), .busy(busy), .fault(fault));

  la_iosequencer #(.SIDES(1), .DELAY(1), .SYNC(2)) dut_b (
    .clk(clk), .reset(reset), .pwrgood(pwrgood_b), .req(req_b),
    .side_en(side_en_b), .side_iso(side_iso_b), .ready(ready_b), .busy(busy_b),
    .fault(fault_b));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode plus edges elapsed since entering it; outputs derived by arithmetic.
  int           m_mode, m_t, m_n0;
  logic [SY-1:0] m_sync;

  function automatic int m_count();
    int c;
    case (m_mode)
      M_RISE:  c = (m_t / D > S) ? S : m_t / D;
      M_ON:    c = S;
      M_FALL:  c = m_n0 - m_t / D;
      default: c = 0;
    endcase
    return c;
  endfunction

  function automatic logic [2*S+2:0] m_expect();
    logic [S-1:0] en;
    en = '0;
    for (int i = 0; i < m_count(); i++) en[i] = 1'b1;
    return {en, ~en, m_mode == M_ON, (m_mode == M_RISE) || (m_mode == M_FALL),
            m_mode == M_FAULT};
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_t = 0; m_n0 = 0; m_sync = '0;
  endtask

  task automatic model_step(input logic r, input logic p);
    logic pg;
    int   n;
    pg = m_sync[SY-1];
    case (m_mode)
      M_OFF: if (r && pg) begin m_mode = M_RISE; m_t = 0; end
      M_RISE: begin
        if (!pg) m_mode = M_FAULT;
        else if (!r) begin
          n = m_count();
          if (n == 0) m_mode = M_OFF;
          else begin m_mode = M_FALL; m_n0 = n; m_t = 0; end
        end else begin
          m_t++;
          if (m_t == (S + 1) * D) m_mode = M_ON;
        end
      end
      M_ON: begin
        if (!pg) m_mode = M_FAULT;
        else if (!r) begin m_mode = M_FALL; m_n0 = S; m_t = 0; end
      end
      M_FALL: begin
        if (!pg) m_mode = M_FAULT;
        else begin
          m_t++;
          if (m_t == m_n0 * D) m_mode = M_OFF;
        end
      end
      default: if (!r) m_mode = M_OFF;
    endcase
    m_sync = {m_sync[SY-2:0], p};
  endtask

  function automatic logic [2*S+2:0] act_a();
    return {side_en, side_iso, ready, busy, fault};
  endfunction

  task automatic cycle(input logic r, input logic p);
    req = r;
    pwrgood = p;
    @(posedge clk);
    model_step(r, p);
    #1;
    check("model", 32'(act_a()), 32'(m_expect()));
  endtask

  typedef struct {
    logic       r;
    logic       p;
    int         n;
    logic [3:0] en;
    logic       rdy;
    logic       bsy;
    logic       flt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic p, input int n, input logic [3:0] en,
                     input logic rdy, input logic bsy, input logic flt);
    vec_t v;
    v.r = r; v.p = p; v.n = n; v.en = en; v.rdy = rdy; v.bsy = bsy; v.flt = flt;
    tbl.push_back(v);
  endtask

  function automatic logic [2*S+2:0] exp_of(input logic [3:0] en, input logic rdy,
                                            input logic bsy, input logic flt);
    return {en, ~en, rdy, bsy, flt};
  endfunction

  initial begin
    reset = 1'b1; pwrgood = 1'b0; req = 1'b0; pwrgood_b = 1'b0; req_b = 1'b0;
    model_reset();
    #1;
    check("reset_a", 32'(act_a()), 32'(exp_of(4'b0000, 0, 0, 0)));
    check("reset_b", 32'({side_en_b, side_iso_b, ready_b, busy_b, fault_b}), 32'(5'b01000));
    #22 reset = 1'b0;

    // Single-side, single-cycle-delay instance; dut_a stays idle meanwhile.
    @(negedge clk);
    pwrgood_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("b_idle", 32'({side_en_b, side_iso_b, ready_b, busy_b, fault_b}), 32'(5'b01000));
    req_b = 1'b1;
    @(posedge clk); #1 check("b_E", 32'({side_en_b, side_iso_b, ready_b, busy_b, fault_b}), 32'(5'b01010));
    @(posedge clk); #1 check("b_E1", 32'({side_en_b, side_iso_b, ready_b, busy_b, fault_b}), 32'(5'b10010));
    @(posedge clk); #1 check("b_E2", 32'({side_en_b, side_iso_b, ready_b, busy_b, fault_b}), 32'(5'b10100));
    req_b = 1'b0;
    @(posedge clk); #1 check("b_F", 32'({side_en_b, side_iso_b, ready_b, busy_b, fault_b}), 32'(5'b10010));
    @(posedge clk); #1 check("b_F1", 32'({side_en_b, side_iso_b, ready_b, busy_b, fault_b}), 32'(5'b01000));

    // Directed vectors: {req, pwrgood, edges to hold, expected outputs after them}.
    add(0, 1, 3,  4'b0000, 0, 0, 0);
    add(1, 1, 1,  4'b0000, 0, 1, 0);
    add(1, 1, 3,  4'b0001, 0, 1, 0);
    add(1, 1, 3,  4'b0011, 0, 1, 0);
    add(1, 1, 3,  4'b0111, 0, 1, 0);
    add(1, 1, 3,  4'b1111, 0, 1, 0);
    add(1, 1, 2,  4'b1111, 0, 1, 0);
    add(1, 1, 1,  4'b1111, 1, 0, 0);
    add(0, 1, 1,  4'b1111, 0, 1, 0);
    add(0, 1, 3,  4'b0111, 0, 1, 0);
    add(0, 1, 3,  4'b0011, 0, 1, 0);
    add(0, 1, 3,  4'b0001, 0, 1, 0);
    add(0, 1, 2,  4'b0001, 0, 1, 0);
    add(0, 1, 1,  4'b0000, 0, 0, 0);
    add(1, 1, 1,  4'b0000, 0, 1, 0);
    add(1, 1, 6,  4'b0011, 0, 1, 0);
    add(0, 1, 1,  4'b0011, 0, 1, 0);
    add(0, 1, 3,  4'b0001, 0, 1, 0);
    add(0, 1, 3,  4'b0000, 0, 0, 0);
    add(1, 1, 1,  4'b0000, 0, 1, 0);
    add(1, 1, 15, 4'b1111, 1, 0, 0);
    add(1, 0, 2,  4'b1111, 1, 0, 0);
    add(1, 0, 1,  4'b0000, 0, 0, 1);
    add(1, 1, 5,  4'b0000, 0, 0, 1);
    add(0, 1, 1,  4'b0000, 0, 0, 0);
    add(1, 1, 1,  4'b0000, 0, 1, 0);
    add(1, 1, 3,  4'b0001, 0, 1, 0);
    add(1, 1, 3,  4'b0011, 0, 1, 0);
    foreach (tbl[k]) begin
      repeat (tbl[k].n) cycle(tbl[k].r, tbl[k].p);
      check($sformatf("vec%0d", k), 32'(act_a()),
            32'(exp_of(tbl[k].en, tbl[k].rdy, tbl[k].bsy, tbl[k].flt)));
    end

    // Asynchronous reset in the middle of bring-up, then restart.
    #2 reset = 1'b1;
    #1 check("async_reset", 32'(act_a()), 32'(exp_of(4'b0000, 0, 0, 0)));
    model_reset();
    #2 reset = 1'b0;
    cycle(1, 1);
    cycle(1, 1);
    check("rst_sync_wait", 32'(act_a()), 32'(exp_of(4'b0000, 0, 0, 0)));
    cycle(1, 1);
    check("rst_restart", 32'(act_a()), 32'(exp_of(4'b0000, 0, 1, 0)));
    repeat (D) cycle(1, 1);
    check("rst_side0", 32'(act_a()), 32'(exp_of(4'b0001, 0, 1, 0)));

    // Random traffic: supply mostly good, request held for random spans.
    for (int seg = 0; seg < 300; seg++) begin
      logic r, p;
      int   len;
      r   = ($urandom_range(0, 99) < 60);
      p   = ($urandom_range(0, 99) < 85);
      len = $urandom_range(1, 20);
      repeat (len) cycle(r, p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
